fetch_sequencer: RTL and testbench

- Multi-cycle instruction-fetch/execute controller sitting between the PC register, the instruction memory port and the execute datapath.
- Issues a handshaked fetch at the current PC and latches the returned instruction.
- Holds the instruction stable while the execute stage is busy, then pulses the PC-advance enable.
- Owns halt detection (exception, exception address, misaligned PC, fetch timeout) and counts retired instructions.

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches at pc, holds the instruction
// through a possibly multi-cycle execute, strobes pc_en and detects halts.
module fetch_sequencer #(
    parameter logic [31:0] ADRS_EXCP      = 32'h8000_0180,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_cpu,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_busy,
    input  logic        excp,
    output logic        pc_en,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] retired,
    output logic [1:0]  state_dbg
);

    // Handshake: imem_req stays high while in FETCH with a legal pc; a
    // transfer completes on the first cycle imem_ack is high with imem_req
    // high. imem_ack while imem_req is low is ignored.

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        RETIRE = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  tmo_cnt, tmo_cnt_next;
    logic [31:0] inst_next;
    logic        inst_valid_next;
    logic        pc_en_next;
    logic        halted_next;
    logic        timeout_err_next;
    logic [31:0] retired_next;
    logic        pc_bad;

    assign pc_bad    = (pc == ADRS_EXCP) || (pc[1:0] != 2'b00);
    // Gated by reset_n so the request drops the instant reset asserts.
    assign imem_req  = reset_n && (state == FETCH) && !pc_bad;
    assign imem_addr = imem_req ? pc : 32'h0;
    assign state_dbg = state;

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            tmo_cnt     <= 8'h0;
            inst        <= 32'h0;
            inst_valid  <= 1'b0;
            pc_en       <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            retired     <= 32'h0;
        end else begin
            state       <= state_next;
            tmo_cnt     <= tmo_cnt_next;
            inst        <= inst_next;
            inst_valid  <= inst_valid_next;
            pc_en       <= pc_en_next;
            halted      <= halted_next;
            timeout_err <= timeout_err_next;
            retired     <= retired_next;
        end
    end

    always_comb begin
        state_next       = state;
        tmo_cnt_next     = tmo_cnt;
        inst_next        = inst;
        inst_valid_next  = inst_valid;
        pc_en_next       = 1'b0;
        halted_next      = halted;
        timeout_err_next = timeout_err;
        retired_next     = retired;
        case (state)
            FETCH: begin
                if (pc_bad) begin
                    state_next  = HALT;
                    halted_next = 1'b1;
                end else if (imem_ack) begin
                    inst_next       = imem_rdata;
                    inst_valid_next = 1'b1;
                    tmo_cnt_next    = 8'h0;
                    state_next      = EXEC;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next       = HALT;
                    halted_next      = 1'b1;
                    timeout_err_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'h1;
                end
            end
            EXEC: begin
                // An exception beats a busy execute stage and retires nothing.
                if (excp) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    inst_valid_next = 1'b0;
                end else if (!exec_busy) begin
                    state_next      = RETIRE;
                    pc_en_next      = 1'b1;
                    inst_valid_next = 1'b0;
                    retired_next    = retired + 32'h1;
                end
            end
            RETIRE: begin
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized runs, each
// cycle compared against an instruction-level model of the sequencer.
module tb_fetch_sequencer;

    localparam logic [31:0] ADRS_EXCP = 32'h8000_0180;
    localparam int          TIMEOUT   = 16;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_busy;
    logic        excp;
    logic        pc_en;
    logic        halted;
    logic        timeout_err;
    logic [31:0] retired;
    logic [1:0]  state_dbg;

    fetch_sequencer #(.ADRS_EXCP(ADRS_EXCP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_cpu(clk_cpu), .reset_n(reset_n), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .exec_busy(exec_busy), .excp(excp), .pc_en(pc_en), .halted(halted),
        .timeout_err(timeout_err), .retired(retired), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk_cpu = ~clk_cpu;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus controls
    int          lat = 0;
    int          ack_wait = 0;
    int          busy_left = 0;
    bit          excp_arm = 1'b0;
    bit          rand_lat = 1'b0;
    bit          rand_busy = 1'b0;
    bit          rand_excp = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    // PC register, memory responder and execute-stage driver
    always @(negedge clk_cpu) begin
        if (pc_en) pc = pc + 32'd4;
        if (imem_req) begin
            if (ack_wait >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = $urandom;
                last_rdata = imem_rdata;
                ack_wait   = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else begin
                imem_ack = 1'b0;
                ack_wait++;
            end
        end else begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            ack_wait   = 0;
        end
        if (inst_valid && busy_left > 0) begin
            exec_busy = 1'b1;
            busy_left--;
        end else begin
            exec_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        if (inst_valid && excp_arm) excp = 1'b1;
        else excp = rand_excp ? ($urandom_range(0, 29) == 0) : 1'b0;
    end

    // instruction-level model: what the sequencer is doing for the current instruction
    logic        m_halted = 1'b0;
    logic        m_tmo = 1'b0;
    logic        m_exec = 1'b0;
    logic        m_bubble = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_retired = 32'h0;
    int          m_wait = 0;

    always @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            m_halted = 1'b0; m_tmo = 1'b0; m_exec = 1'b0; m_bubble = 1'b0;
            m_inst = 32'h0; m_retired = 32'h0; m_wait = 0;
        end else if (!m_halted) begin
            if (m_exec) begin
                if (excp) begin
                    m_exec = 1'b0;
                    m_halted = 1'b1;
                end else if (!exec_busy) begin
                    m_exec = 1'b0;
                    m_bubble = 1'b1;
                    m_retired = m_retired + 32'd1;
                end
            end else if (m_bubble) begin
                m_bubble = 1'b0;
            end else if (pc == ADRS_EXCP || pc[1:0] != 2'b00) begin
                m_halted = 1'b1;
            end else if (imem_ack) begin
                m_inst = imem_rdata;
                m_exec = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_halted = 1'b1;
                    m_tmo = 1'b1;
                end
            end
        end
    end

    // scoreboard: compare every cycle at the falling edge
    always @(negedge clk_cpu) begin
        logic        fetching;
        logic        exp_req;
        if (chk_en) begin
            fetching = !(m_halted || m_exec || m_bubble);
            exp_req  = reset_n && fetching && (pc != ADRS_EXCP) && (pc[1:0] == 2'b00);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            check("imem_addr", imem_addr, exp_req ? pc : 32'h0);
            check("inst", inst, m_inst);
            check("inst_valid", 32'(inst_valid), 32'(m_exec));
            check("pc_en", 32'(pc_en), 32'(m_bubble));
            check("halted", 32'(halted), 32'(m_halted));
            check("timeout_err", 32'(timeout_err), 32'(m_tmo));
            check("retired", retired, m_retired);
            check("tmo_implies_halt", 32'(timeout_err && !halted), 32'h0);
        end
    end

    // driver tasks
    task automatic do_reset(input logic [31:0] start_pc);
        @(negedge clk_cpu);
        #2 reset_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_pc_en", 32'(pc_en), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_tmo", 32'(timeout_err), 32'h0);
        check("rst_retired", retired, 32'h0);
        pc = start_pc;
        busy_left = 0;
        excp_arm = 1'b0;
        @(posedge clk_cpu);
        @(posedge clk_cpu);
        #1 reset_n = 1'b1;
    endtask

    task automatic window(input int n, output int req_c, output int iv_c, output int pe_c);
        req_c = 0; iv_c = 0; pe_c = 0;
        repeat (n) begin
            @(negedge clk_cpu);
            #1;
            req_c += int'(imem_req);
            iv_c  += int'(inst_valid);
            pe_c  += int'(pc_en);
        end
    endtask

    initial begin
        int rq, iv, pe;
        reset_n = 1'b0; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        exec_busy = 1'b0; excp = 1'b0;
        repeat (2) @(posedge clk_cpu);
        chk_en = 1'b1;

        // zero-wait memory, 3-cycle cadence
        lat = 0;
        do_reset(32'h0040_0000);
        @(negedge clk_cpu);
        #1 check("a_first_addr", imem_addr, 32'h0040_0000);
        repeat (30) @(negedge clk_cpu);
        #1;
        check("a_retired10", retired, 32'd10);
        check("a_pc_after10", pc, 32'h0040_0028);

        // ack delayed by 4 cycles
        lat = 4;
        do_reset(32'h0040_1000);
        window(6, rq, iv, pe);
        check("b_req_cycles", 32'(rq), 32'd5);
        check("b_no_pc_en", 32'(pe), 32'd0);
        check("b_inst", inst, last_rdata);

        // exec_busy for 6 cycles
        lat = 0;
        do_reset(32'h0040_2000);
        busy_left = 6;
        window(10, rq, iv, pe);
        check("c_valid_cycles", 32'(iv), 32'd7);
        check("c_pc_en_pulses", 32'(pe), 32'd1);
        check("c_retired", retired, 32'd1);

        // exception while busy
        do_reset(32'h0040_3000);
        excp_arm = 1'b1;
        busy_left = 3;
        window(3, rq, iv, pe);
        check("d_halted", 32'(halted), 32'd1);
        check("d_retired", retired, 32'd0);
        check("d_no_pc_en", 32'(pe), 32'd0);
        excp_arm = 1'b0;
        busy_left = 0;

        // misaligned pc and exception address at FETCH
        do_reset(32'h0040_0002);
        window(2, rq, iv, pe);
        check("e_mis_req", 32'(rq), 32'd0);
        check("e_mis_halted", 32'(halted), 32'd1);
        do_reset(ADRS_EXCP);
        window(2, rq, iv, pe);
        check("e_exc_req", 32'(rq), 32'd0);
        check("e_exc_halted", 32'(halted), 32'd1);

        // fetch timeout
        lat = 255;
        do_reset(32'h0040_4000);
        repeat (16) @(negedge clk_cpu);
        #1 check("f_not_yet", 32'(halted), 32'd0);
        @(negedge clk_cpu);
        #1;
        check("f_halted", 32'(halted), 32'd1);
        check("f_tmo", 32'(timeout_err), 32'd1);
        check("f_req_low", 32'(imem_req), 32'd0);

        // reset mid-fetch, then a fresh fetch
        do_reset(32'h0040_5000);
        repeat (3) @(negedge clk_cpu);
        lat = 0;
        do_reset(32'h0040_5000);
        @(negedge clk_cpu);
        #1 check("g_fresh_req", 32'(imem_req), 32'd1);

        // retired wraps to zero
        lat = 3;
        do_reset(32'h0040_6000);
        @(negedge clk_cpu);
        #2 force dut.retired = 32'hFFFF_FFFF;
        m_retired = 32'hFFFF_FFFF;
        #1 release dut.retired;
        repeat (6) @(negedge clk_cpu);
        #1 check("h_wrap", retired, 32'h0);

        // randomized runs
        rand_lat = 1'b1; rand_busy = 1'b1; rand_excp = 1'b1;
        for (int r = 0; r < 20; r++) begin
            logic [31:0] sp;
            if ($urandom_range(0, 3) == 0) sp = ADRS_EXCP - 32'(4 * $urandom_range(1, 5));
            else sp = {16'h0040, 4'h0, 10'($urandom), 2'b00};
            lat = $urandom_range(0, 3);
            do_reset(sp);
            repeat (150) @(negedge clk_cpu);
        end

        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
